// File: rtl/dl_string_ctrl.sv
// Karplus-Strong plucked-string controller: drives an external delay-line RAM,
// fills it with LFSR noise on a pluck and runs the averaging loop filter on each tick.
module dl_string_ctrl #(
    parameter int          AW        = 11,
    parameter int          DW        = 18,
    parameter logic [22:0] LFSR_SEED = 23'h000001
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          pluck,
    input  logic [AW-1:0] len,
    input  logic [7:0]    gain,
    output logic [AW-1:0] dl_a,
    output logic [DW-1:0] dl_i,
    output logic          dl_wrt,
    input  logic [DW-1:0] dl_o,
    output logic [DW-1:0] sample_out,
    output logic          sample_valid,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, EXCITE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] ecnt_q, ecnt_d;
    logic [AW-1:0] len_r_q, len_r_d;
    logic [DW-1:0] cur_q, cur_d;
    logic [DW-1:0] prev_q, prev_d;
    logic [DW-1:0] sample_out_q, sample_out_d;
    logic          sample_valid_q, sample_valid_d;
    logic          pluck_pend_q, pluck_pend_d;
    logic [22:0]   lfsr_q, lfsr_d;

    logic          pend_eff;
    logic [AW-1:0] len_clamped;
    logic [22:0]   lfsr_step;

    logic signed [DW:0]   sum_s;
    logic signed [DW:0]   avg_s;
    logic signed [DW+9:0] avg_x;
    logic signed [DW+9:0] gain_x;
    logic signed [DW+9:0] prod_s;
    logic signed [DW+9:0] y_full;
    logic [DW-1:0]        y;

    // A pluck in the same cycle as a tick must already win in IDLE.
    assign pend_eff    = pluck | pluck_pend_q;
    assign len_clamped = (len < AW'(2)) ? AW'(2) : len;
    assign lfsr_step   = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};

    // Loop filter: halve the two-tap sum, then scale by gain/256; |y| <= |avg| so no clipping.
    assign sum_s  = $signed({cur_q[DW-1], cur_q}) + $signed({prev_q[DW-1], prev_q});
    assign avg_s  = sum_s >>> 1;
    assign avg_x  = {{9{avg_s[DW]}}, avg_s};
    assign gain_x = {{(DW+2){1'b0}}, gain};
    assign prod_s = avg_x * gain_x;
    assign y_full = prod_s >>> 8;
    assign y      = y_full[DW-1:0];

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        ecnt_d         = ecnt_q;
        len_r_d        = len_r_q;
        cur_d          = cur_q;
        prev_d         = prev_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        pluck_pend_d   = pend_eff;
        lfsr_d         = lfsr_q;
        dl_a           = ptr_q;
        dl_i           = '0;
        dl_wrt         = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_eff) begin
                    state_d      = EXCITE;
                    pluck_pend_d = 1'b0;
                    len_r_d      = len_clamped;
                    ecnt_d       = '0;
                    ptr_d        = '0;
                    prev_d       = '0;
                end else if (tick) begin
                    state_d = READ;
                    len_r_d = len_clamped;
                end
            end
            READ: begin
                cur_d          = dl_o;
                sample_out_d   = dl_o;
                sample_valid_d = 1'b1;
                state_d        = WRITE;
            end
            WRITE: begin
                dl_i    = y;
                dl_wrt  = 1'b1;
                prev_d  = cur_q;
                // >= so a shortened length pulls an out-of-range pointer back to 0.
                ptr_d   = (ptr_q >= len_r_q - AW'(1)) ? '0 : ptr_q + AW'(1);
                state_d = IDLE;
            end
            EXCITE: begin
                dl_a   = ecnt_q;
                dl_i   = lfsr_q[DW-1:0];
                dl_wrt = 1'b1;
                ecnt_d = ecnt_q + AW'(1);
                lfsr_d = lfsr_step;
                if (ecnt_q == len_r_q - AW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            ecnt_q         <= '0;
            len_r_q        <= AW'(2);
            cur_q          <= '0;
            prev_q         <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            pluck_pend_q   <= 1'b0;
            lfsr_q         <= LFSR_SEED;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            ecnt_q         <= ecnt_d;
            len_r_q        <= len_r_d;
            cur_q          <= cur_d;
            prev_q         <= prev_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            pluck_pend_q   <= pluck_pend_d;
            lfsr_q         <= lfsr_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q == EXCITE);

endmodule

// File: tb/tb_dl_string_ctrl.sv
// Bench for dl_string_ctrl: behavioural delay-line RAM plus a Karplus-Strong
// reference model feeding expected-sample and expected-write queues.
module tb_dl_string_ctrl;

    localparam int AW = 11;
    localparam int DW = 18;
    localparam logic [22:0] SEED = 23'h000001;

    logic          clk;
    logic          reset_n;
    logic          tick;
    logic          pluck;
    logic [AW-1:0] len;
    logic [7:0]    gain;
    logic [AW-1:0] dl_a;
    logic [DW-1:0] dl_i;
    logic          dl_wrt;
    logic [DW-1:0] dl_o;
    logic [DW-1:0] sample_out;
    logic          sample_valid;
    logic          busy;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          preload_req;
    logic [DW-1:0] preload_val;

    logic [DW-1:0] m_ram [0:(1<<AW)-1];
    int            m_ptr;
    int            m_len;
    logic [DW-1:0] m_prev;
    logic [22:0]   m_lfsr;

    logic [DW-1:0]    exp_sample [$];
    logic [AW+DW-1:0] exp_wr [$];

    dl_string_ctrl #(.AW(AW), .DW(DW), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .pluck(pluck),
        .len(len), .gain(gain), .dl_a(dl_a), .dl_i(dl_i), .dl_wrt(dl_wrt),
        .dl_o(dl_o), .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dl_o = mem[dl_a];
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= preload_val;
        end else if (dl_wrt) begin
            mem[dl_a] <= dl_i;
        end
    end

    function automatic logic [DW-1:0] model_y(input logic [DW-1:0] c,
                                              input logic [DW-1:0] p,
                                              input logic [7:0] g);
        int s, a, yy;
        s  = int'($signed(c)) + int'($signed(p));
        a  = s >>> 1;
        yy = (a * int'(g)) >>> 8;
        return yy[DW-1:0];
    endfunction

    task automatic preload(input logic [DW-1:0] v);
        preload_val = v;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        for (int i = 0; i < (1 << AW); i++) m_ram[i] = v;
    endtask

    task automatic do_excite(input int l, input bit with_tick);
        int ml, k, first, stray;
        logic [22:0] lf;
        logic [AW+DW-1:0] e;
        ml = (l < 2) ? 2 : l;
        lf = m_lfsr;
        for (int i = 0; i < ml; i++) begin
            exp_wr.push_back({AW'(i), lf[DW-1:0]});
            lf = {lf[21:0], lf[22] ^ lf[17]};
        end
        len = AW'(l); pluck = 1'b1; tick = with_tick;
        k = 0; first = -1; stray = 0;
        for (int c = 0; c < ml + 3; c++) begin
            @(negedge clk);
            pluck = 1'b0; tick = 1'b0;
            if (sample_valid) stray++;
            if (busy) begin
                if (first < 0) first = c;
                e = (exp_wr.size() > 0) ? exp_wr.pop_front() : '1;
                tests++;
                if ({dl_wrt, dl_a, dl_i} !== {1'b1, e})
                    begin fails++; $display("FAIL excite_write k=%0d: got wrt=%b a=%0d d=%h, want wrt=1 a=%0d d=%h", k, dl_wrt, dl_a, dl_i, e[AW+DW-1:DW], e[DW-1:0]); end
                m_ram[k] = e[DW-1:0];
                k++;
            end else if (dl_wrt) begin
                stray++;
            end
        end
        tests++;
        if (k !== ml) begin fails++; $display("FAIL excite_busy_len: got %0d cycles, want %0d", k, ml); end
        tests++;
        if (first !== 0) begin fails++; $display("FAIL excite_start: busy first at %0d, want 0", first); end
        tests++;
        if (stray !== 0) begin fails++; $display("FAIL excite_stray: got %0d stray valid/writes, want 0", stray); end
        exp_wr.delete();
        m_lfsr = lf; m_ptr = 0; m_prev = '0; m_len = ml;
        $display("[TB] excite len=%0d busy_cycles=%0d", l, k);
    endtask

    task automatic do_tick(input bit dup);
        logic [DW-1:0] cur, y, es;
        logic [AW+DW-1:0] ew;
        int lat, nv;
        m_len = (int'(len) < 2) ? 2 : int'(len);
        cur = m_ram[m_ptr];
        y   = model_y(cur, m_prev, gain);
        exp_sample.push_back(cur);
        exp_wr.push_back({AW'(m_ptr), y});
        tick = 1'b1; lat = -1; nv = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            tick = dup && (c == 1);
            if (sample_valid) begin
                nv++;
                if (lat < 0) begin
                    lat = c;
                    es = (exp_sample.size() > 0) ? exp_sample.pop_front() : '1;
                    ew = (exp_wr.size() > 0) ? exp_wr.pop_front() : '1;
                    tests++;
                    if (sample_out !== es) begin fails++; $display("FAIL tick_sample: got %h, want %h", sample_out, es); end
                    tests++;
                    if ({dl_wrt, dl_a, dl_i} !== {1'b1, ew})
                        begin fails++; $display("FAIL tick_write: got wrt=%b a=%0d d=%h, want wrt=1 a=%0d d=%h", dl_wrt, dl_a, dl_i, ew[AW+DW-1:DW], ew[DW-1:0]); end
                end
            end
        end
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL tick_latency: got %0d, want 2", lat); end
        tests++;
        if (nv !== 1) begin fails++; $display("FAIL tick_valid_count: got %0d, want 1", nv); end
        exp_sample.delete(); exp_wr.delete();
        $display("[TB] tick ptr=%0d sample=%h y=%h", m_ptr, cur, y);
        m_ram[m_ptr] = y;
        m_prev = cur;
        m_ptr  = (m_ptr >= m_len - 1) ? 0 : m_ptr + 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; tick = 1'b0; pluck = 1'b0; len = AW'(2); gain = 8'd0;
        preload_req = 1'b0; preload_val = '0;
        #2 reset_n = 1'b0;
        preload('0);
        @(negedge clk);
        tests++;
        if ({sample_out, sample_valid, dl_wrt, busy, dl_a, dl_i} !== '0)
            begin fails++; $display("FAIL reset_state: so=%h sv=%b wrt=%b busy=%b a=%0d d=%h, want all 0", sample_out, sample_valid, dl_wrt, busy, dl_a, dl_i); end
        reset_n = 1'b1;
        m_lfsr = SEED; m_ptr = 0; m_prev = '0; m_len = 2;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests++;
            if ({sample_out, sample_valid, dl_wrt, busy} !== '0)
                begin fails++; $display("FAIL idle_quiet c=%0d: so=%h sv=%b wrt=%b busy=%b, want 0", c, sample_out, sample_valid, dl_wrt, busy); end
        end
        $display("[TB] reset and idle checked");
    endtask

    task automatic test_excite();
        gain = 8'd255;
        do_excite(8, 1'b0);
    endtask

    task automatic test_karplus();
        gain = 8'd255; len = AW'(8);
        for (int i = 0; i < 16; i++) begin
            do_tick(1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_len_shrink();
        len = AW'(8);
        for (int i = 0; i < 5; i++) do_tick(1'b0);
        len = AW'(4);
        do_tick(1'b0);
        do_tick(1'b0);
    endtask

    task automatic test_filter();
        do_excite(4, 1'b0);
        preload(18'd1000);
        gain = 8'd128;
        do_tick(1'b0);
        do_tick(1'b0);
        gain = 8'd0;
        do_tick(1'b0);
    endtask

    task automatic test_tick_pluck();
        gain = 8'd200;
        do_excite(4, 1'b1);
        do_tick(1'b1);
    endtask

    task automatic test_reset_excite();
        int found;
        preload('0);
        len = AW'(8); pluck = 1'b1; found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            pluck = 1'b0;
            if (busy && dl_a == AW'(3)) found = 1;
        end
        tests++;
        if (found !== 1) begin fails++; $display("FAIL rst_excite_reach: ecnt=3 not seen, got %0d want 1", found); end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if ({dl_wrt, busy, sample_valid} !== 3'b000)
            begin fails++; $display("FAIL rst_excite_abort: wrt=%b busy=%b sv=%b, want 000", dl_wrt, busy, sample_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        tests++;
        if (mem[3] !== '0) begin fails++; $display("FAIL rst_excite_nowrite: mem[3]=%h, want 0", mem[3]); end
        for (int i = 0; i < 3; i++) m_ram[i] = mem[i];
        m_lfsr = SEED; m_ptr = 0; m_prev = '0; m_len = 2;
        $display("[TB] reset during excite applied");
        do_excite(2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_excite();
        test_karplus();
        test_len_shrink();
        test_filter();
        test_tick_pluck();
        test_reset_excite();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
